// File: rtl/conv_cmd_if.sv
// Command/stream bundle between the MicroBlaze GPIO side and the conv command controller.
// Input names keep their i_ prefix and output names their o_ prefix, as seen from the controller.
interface conv_cmd_if #(
  parameter int DATA_W   = 24,
  parameter int OP_W     = 3,
  parameter int LEN_W    = 10,
  parameter int KNL_ROWS = 3,
  parameter int MCU_W    = 8
);
  localparam int ROW_W = (KNL_ROWS > 1) ? $clog2(KNL_ROWS) : 1;

  logic [DATA_W-1:0] i_GPIOdata;
  logic [OP_W-1:0]   i_GPIOctrl;
  logic              i_GPIOvalid;
  logic [MCU_W-1:0]  i_MCUdata;
  logic              i_EOP_from_FSM;
  logic [31:0]       o_GPIOdata;
  logic [DATA_W-1:0] o_KNLdata;
  logic [ROW_W-1:0]  o_knl_row;
  logic              o_valid_to_CONV;
  logic [DATA_W-1:0] o_IMGdata;
  logic              o_valid_to_FSM;
  logic [LEN_W-1:0]  o_imgLength;
  logic              o_load;
  logic              o_run;
  logic              o_EOP_to_MCU;
  logic              o_err;
  logic [2:0]        o_state;

  modport slave (
    input  i_GPIOdata, i_GPIOctrl, i_GPIOvalid, i_MCUdata, i_EOP_from_FSM,
    output o_GPIOdata, o_KNLdata, o_knl_row, o_valid_to_CONV, o_IMGdata, o_valid_to_FSM,
    output o_imgLength, o_load, o_run, o_EOP_to_MCU, o_err, o_state
  );

  modport master (
    output i_GPIOdata, i_GPIOctrl, i_GPIOvalid, i_MCUdata, i_EOP_from_FSM,
    input  o_GPIOdata, o_KNLdata, o_knl_row, o_valid_to_CONV, o_IMGdata, o_valid_to_FSM,
    input  o_imgLength, o_load, o_run, o_EOP_to_MCU, o_err, o_state
  );
endinterface

// File: rtl/conv_cmd_ctrl.sv
// GPIO command decoder for the 2D-convolution engine: loads kernels and pixels,
// hands over to the conv FSM during RUN and holds a sticky done flag until acknowledged.
module conv_cmd_ctrl #(
    parameter int DATA_W   = 24,
    parameter int OP_W     = 3,
    parameter int LEN_W    = 10,
    parameter int KNL_ROWS = 3,
    parameter int MCU_W    = 8
) (
    input logic     i_CLK,
    input logic     i_rst,
    conv_cmd_if.slave bus
);
    localparam int ROW_W = (KNL_ROWS > 1) ? $clog2(KNL_ROWS) : 1;

    localparam logic [OP_W-1:0] OP_KNL_LOAD    = OP_W'(0);
    localparam logic [OP_W-1:0] OP_SIZE_LOAD   = OP_W'(1);
    localparam logic [OP_W-1:0] OP_IMG_LOAD    = OP_W'(2);
    localparam logic [OP_W-1:0] OP_DATA_REQ    = OP_W'(3);
    localparam logic [OP_W-1:0] OP_GO_RUN      = OP_W'(4);
    localparam logic [OP_W-1:0] OP_STATUS_READ = OP_W'(5);
    localparam logic [OP_W-1:0] OP_ACK_EOP     = OP_W'(6);
    localparam logic [OP_W-1:0] OP_SOFT_RESET  = OP_W'(7);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD_IMG = 3'd1,
        S_RUN      = 3'd2,
        S_DONE     = 3'd3
    } state_t;

    state_t           state;
    logic             valid_prev;
    logic             strobe;
    logic             soft_rst;
    logic [ROW_W-1:0] knl_cnt;
    logic             kernel_complete;
    logic             size_valid;
    logic [LEN_W-1:0] len_field;

    assign strobe    = bus.i_GPIOvalid & ~valid_prev;
    assign soft_rst  = strobe && (bus.i_GPIOctrl == OP_SOFT_RESET);
    assign len_field = bus.i_GPIOdata[LEN_W-1:0];
    assign bus.o_state = state;

    function automatic logic [31:0] status_word(input state_t st, input logic err, input logic eop,
                                                input logic kc, input logic sv,
                                                input logic [LEN_W-1:0] len);
        logic [31:0] w;
        w            = '0;
        w[31:29]     = st;
        w[28]        = err;
        w[27]        = eop;
        w[26]        = kc;
        w[25]        = sv;
        w[LEN_W-1:0] = len;
        return w;
    endfunction

    // Edge detector keeps tracking the strobe line through a soft reset.
    always_ff @(posedge i_CLK) begin
        if (i_rst) valid_prev <= 1'b0;
        else       valid_prev <= bus.i_GPIOvalid;
    end

    always_ff @(posedge i_CLK) begin
        if (i_rst || soft_rst) begin
            state               <= S_IDLE;
            knl_cnt             <= '0;
            kernel_complete     <= 1'b0;
            size_valid          <= 1'b0;
            bus.o_GPIOdata      <= '0;
            bus.o_KNLdata       <= '0;
            bus.o_knl_row       <= '0;
            bus.o_valid_to_CONV <= 1'b0;
            bus.o_IMGdata       <= '0;
            bus.o_valid_to_FSM  <= 1'b0;
            bus.o_imgLength     <= '0;
            bus.o_load          <= 1'b0;
            bus.o_run           <= 1'b0;
            bus.o_EOP_to_MCU    <= 1'b0;
            bus.o_err           <= 1'b0;
        end else begin
            bus.o_valid_to_CONV <= 1'b0;
            bus.o_valid_to_FSM  <= 1'b0;

            if (strobe) begin
                case (bus.i_GPIOctrl)
                    OP_KNL_LOAD: begin
                        if (state == S_IDLE) begin
                            bus.o_KNLdata       <= bus.i_GPIOdata;
                            bus.o_knl_row       <= knl_cnt;
                            bus.o_valid_to_CONV <= 1'b1;
                            // Starting a new kernel invalidates the old one until its last row lands.
                            if (knl_cnt == '0 && kernel_complete) kernel_complete <= 1'b0;
                            if (knl_cnt == ROW_W'(KNL_ROWS - 1)) begin
                                knl_cnt         <= '0;
                                kernel_complete <= 1'b1;
                            end else begin
                                knl_cnt <= knl_cnt + ROW_W'(1);
                            end
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                    OP_SIZE_LOAD: begin
                        if (state == S_IDLE && len_field != '0) begin
                            bus.o_imgLength <= len_field;
                            size_valid      <= 1'b1;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                    OP_IMG_LOAD: begin
                        if ((state == S_IDLE && size_valid) || state == S_LOAD_IMG) begin
                            state              <= S_LOAD_IMG;
                            bus.o_load         <= 1'b1;
                            bus.o_IMGdata      <= bus.i_GPIOdata;
                            bus.o_valid_to_FSM <= 1'b1;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                    OP_DATA_REQ: begin
                        if (state == S_IDLE || state == S_DONE) bus.o_GPIOdata <= 32'(bus.i_MCUdata);
                        else                                    bus.o_err      <= 1'b1;
                    end
                    OP_GO_RUN: begin
                        if (state == S_LOAD_IMG && kernel_complete) begin
                            state      <= S_RUN;
                            bus.o_run  <= 1'b1;
                            bus.o_load <= 1'b0;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                    OP_STATUS_READ: begin
                        bus.o_GPIOdata <= status_word(state, bus.o_err, bus.o_EOP_to_MCU,
                                                      kernel_complete, size_valid, bus.o_imgLength);
                    end
                    OP_ACK_EOP: begin
                        if (state == S_DONE) begin
                            state            <= S_IDLE;
                            bus.o_EOP_to_MCU <= 1'b0;
                        end else begin
                            bus.o_err <= 1'b1;
                        end
                    end
                    default: bus.o_err <= 1'b1;
                endcase
            end

            // A RUN-state strobe never moves the state, so completion always wins here.
            if (state == S_RUN && bus.i_EOP_from_FSM) begin
                state            <= S_DONE;
                bus.o_run        <= 1'b0;
                bus.o_EOP_to_MCU <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_conv_cmd_ctrl.sv
// Directed bench for conv_cmd_ctrl: command sequences with hand-computed expectations.
module tb_conv_cmd_ctrl;
    localparam int DATA_W   = 24;
    localparam int OP_W     = 3;
    localparam int LEN_W    = 10;
    localparam int KNL_ROWS = 3;
    localparam int MCU_W    = 8;

    localparam logic [2:0] KNL = 3'd0, SIZE = 3'd1, IMG = 3'd2, DREQ = 3'd3;
    localparam logic [2:0] GO = 3'd4, STAT = 3'd5, ACK = 3'd6, SRST = 3'd7;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    conv_cmd_if #(.DATA_W(DATA_W), .OP_W(OP_W), .LEN_W(LEN_W), .KNL_ROWS(KNL_ROWS), .MCU_W(MCU_W)) bus ();

    conv_cmd_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W), .LEN_W(LEN_W), .KNL_ROWS(KNL_ROWS), .MCU_W(MCU_W)) dut (
        .i_CLK(clk),
        .i_rst(rst),
        .bus  (bus)
    );

    int total = 0;
    int bad = 0;
    int conv_cnt = 0;
    int fsm_cnt = 0;
    logic [1:0] rows[8];
    int conv_before;
    int fsm_before;

    // Pulses are counted just after each rising edge, clear of the negedge checks.
    always @(posedge clk) begin
        #1;
        if (bus.o_valid_to_CONV === 1'b1) begin
            if (conv_cnt < 8) rows[conv_cnt] = bus.o_knl_row;
            conv_cnt++;
        end
        if (bus.o_valid_to_FSM === 1'b1) fsm_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $display("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
            $error("check %s", tag);
        end
    endtask

    task automatic send(input logic [2:0] op, input logic [23:0] d, input int hold);
        @(negedge clk);
        bus.i_GPIOctrl  = op;
        bus.i_GPIOdata  = d;
        bus.i_GPIOvalid = 1'b1;
        repeat (hold) @(negedge clk);
        bus.i_GPIOvalid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        bus.i_GPIOdata     = '0;
        bus.i_GPIOctrl     = '0;
        bus.i_GPIOvalid    = 1'b0;
        bus.i_MCUdata      = '0;
        bus.i_EOP_from_FSM = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_state", 32'(bus.o_state), 32'd0);
        check("rst_gpio", bus.o_GPIOdata, 32'd0);
        check("rst_flags", {28'd0, bus.o_load, bus.o_run, bus.o_EOP_to_MCU, bus.o_err}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Full kernel
        send(KNL, 24'h010203, 1);
        send(KNL, 24'h040506, 1);
        send(KNL, 24'h070809, 1);
        check("knl_pulses", 32'(conv_cnt), 32'd3);
        check("knl_rows", {26'd0, rows[0], rows[1], rows[2]}, {26'd0, 2'd0, 2'd1, 2'd2});
        check("knl_data", 32'(bus.o_KNLdata), 32'h070809);
        send(STAT, 24'd0, 1);
        check("stat_kc", bus.o_GPIOdata, 32'h0400_0000);

        // Size and four held-high pixel strobes
        send(SIZE, 24'h000040, 1);
        send(IMG, 24'h0A0B0C, 5);
        send(IMG, 24'h0D0E0F, 5);
        send(IMG, 24'h101112, 5);
        send(IMG, 24'h131415, 5);
        check("img_len", 32'(bus.o_imgLength), 32'd64);
        check("img_pulses", 32'(fsm_cnt), 32'd4);
        check("img_load", {31'd0, bus.o_load}, 32'd1);
        check("img_state", 32'(bus.o_state), 32'd1);
        check("img_data", 32'(bus.o_IMGdata), 32'h131415);

        // GO_RUN without a complete kernel
        send(SRST, 24'd0, 1);
        send(STAT, 24'd0, 1);
        check("srst_status", bus.o_GPIOdata, 32'd0);
        send(SIZE, 24'h000040, 1);
        send(IMG, 24'h111111, 1);
        send(GO, 24'd0, 1);
        check("go_nokrn_err", {31'd0, bus.o_err}, 32'd1);
        check("go_nokrn_run", {31'd0, bus.o_run}, 32'd0);
        check("go_nokrn_state", 32'(bus.o_state), 32'd1);

        // Soft reset then a proper run
        send(SRST, 24'd0, 1);
        check("srst_err", {31'd0, bus.o_err}, 32'd0);
        send(KNL, 24'h0A0A0A, 1);
        send(KNL, 24'h0B0B0B, 1);
        send(KNL, 24'h0C0C0C, 1);
        send(SIZE, 24'h000040, 1);
        send(IMG, 24'h222222, 1);
        send(GO, 24'd0, 1);
        check("run_flags", {29'd0, bus.o_run, bus.o_load, bus.o_err}, {29'd0, 1'b1, 1'b0, 1'b0});
        check("run_state", 32'(bus.o_state), 32'd2);

        // Illegal kernel write during RUN
        conv_before = conv_cnt;
        send(KNL, 24'hFFFFFF, 1);
        check("run_knl_err", {31'd0, bus.o_err}, 32'd1);
        check("run_knl_nopulse", 32'(conv_cnt), 32'(conv_before));
        check("run_knl_state", 32'(bus.o_state), 32'd2);

        // End of processing
        @(negedge clk);
        bus.i_EOP_from_FSM = 1'b1;
        @(negedge clk);
        bus.i_EOP_from_FSM = 1'b0;
        check("eop_state", 32'(bus.o_state), 32'd3);
        check("eop_flags", {30'd0, bus.o_run, bus.o_EOP_to_MCU}, {30'd0, 1'b0, 1'b1});
        repeat (4) @(negedge clk);
        check("eop_sticky", {31'd0, bus.o_EOP_to_MCU}, 32'd1);

        // Readback in DONE
        bus.i_MCUdata = 8'hA5;
        send(DREQ, 24'd0, 1);
        check("dreq_done", bus.o_GPIOdata, 32'h0000_00A5);
        send(STAT, 24'd0, 1);
        check("stat_done", bus.o_GPIOdata, 32'h7E00_0040);
        send(ACK, 24'd0, 1);
        check("ack_eop", {31'd0, bus.o_EOP_to_MCU}, 32'd0);
        check("ack_state", 32'(bus.o_state), 32'd0);

        // Reset in LOAD_IMG concurrent with a pixel strobe
        send(IMG, 24'h333333, 1);
        check("pre_rst_state", 32'(bus.o_state), 32'd1);
        fsm_before = fsm_cnt;
        @(negedge clk);
        rst = 1'b1;
        bus.i_GPIOctrl  = IMG;
        bus.i_GPIOdata  = 24'h444444;
        bus.i_GPIOvalid = 1'b1;
        @(negedge clk);
        check("midrst_nopulse", 32'(fsm_cnt), 32'(fsm_before));
        check("midrst_state", 32'(bus.o_state), 32'd0);
        check("midrst_img", 32'(bus.o_IMGdata), 32'd0);
        check("midrst_flags", {28'd0, bus.o_load, bus.o_run, bus.o_EOP_to_MCU, bus.o_err}, 32'd0);
        check("midrst_len", 32'(bus.o_imgLength), 32'd0);
        rst = 1'b0;
        bus.i_GPIOvalid = 1'b0;
        @(negedge clk);

        // Zero length is rejected
        send(SIZE, 24'd0, 1);
        check("size0_err", {31'd0, bus.o_err}, 32'd1);
        send(STAT, 24'd0, 1);
        check("size0_status", bus.o_GPIOdata, 32'h1000_0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
